instruction_fetch_controller: RTL and testbench
===============================================

# instruction_fetch_controller

Sequences instruction fetches for the ECO32 CPU. It accepts a fetch request from the CPU control unit, runs one word read on the memory bus at the current PC, and asserts the load enable of the current instruction register in the exact cycle the bus returns valid data. It reports completion, or a fault (misaligned PC, bus error, optional timeout), back to the control unit. It sits between the control unit, the bus master port and the current instruction register.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: number of REQUEST cycles without `busAck` before a timeout fault. Valid range is 2..2^COUNTER_WIDTH-1.
- COUNTER_WIDTH, 8: width of the wait-cycle counter.

Ports:
- clock  in  1  the single clock; all state changes on its rising edge
- resetN  in  1  asynchronous, active-low reset
- fetchRequest  in  1  start a fetch; sampled only in IDLE
- pc  in  32  fetch address; sampled together with an accepted `fetchRequest`
- abort  in  1  cancel an in-flight fetch (exception or interrupt path)
- busRequest  out  1  bus read request, held until ack, abort or fault
- busAddress  out  32  latched fetch address
- busAck  in  1  bus cycle complete, read data valid this cycle
- busError  in  1  bus error; meaningful only while `busAck`=1
- instructionRegisterWriteEnable  out  1  load enable for the current instruction register
- fetchDone  out  1  one-cycle pulse: instruction register holds the new word
- fetchFault  out  1  one-cycle pulse: fetch failed
- faultCode  out  2  00 none, 01 misaligned, 10 bus error, 11 timeout
- busy  out  1  high when the state is not IDLE

## Operation
- States: IDLE, REQUEST, DONE, FAULT.
- **IDLE:**
  - If `fetchRequest`=1 and `pc[1:0]`=00: latch `pc` into `busAddress`, clear the counter, set `faultCode`=00, go to REQUEST.
  - If `fetchRequest`=1 and `pc[1:0]`≠00: set `faultCode`=01, go to FAULT. No bus request is issued.
- **REQUEST:** `busRequest`=1. Priority is abort > ack > timeout.
  - `abort`=1: go to IDLE. No write enable, no done, no fault. Any `busAck` in the same cycle is discarded.
  - `busAck`=1 with `busError`=0: `instructionRegisterWriteEnable`=1 combinationally in this cycle, so the register captures bus data on this edge. Go to DONE.
  - `busAck`=1 with `busError`=1: no write enable. Set `faultCode`=10, go to FAULT.
  - Otherwise: increment the counter. When the counter equals TIMEOUT_CYCLES-1, set `faultCode`=11 and go to FAULT.
- **DONE:** `fetchDone`=1 for one cycle, then IDLE.
- **FAULT:** `fetchFault`=1 for one cycle, then IDLE.
- `faultCode` holds its value until the next accepted fetch.
- `fetchRequest` is ignored outside IDLE. `abort` is ignored outside REQUEST.
- `instructionRegisterWriteEnable` is asserted only as stated above: at most once per fetch, never in any other state.
- Counter saturates and never wraps.

## Timing
- Reset values: state IDLE; `busRequest`, `instructionRegisterWriteEnable`, `fetchDone`, `fetchFault`, `busy` = 0; `faultCode`=00; `busAddress`=0; counter 0.
- Reset asserted mid-fetch forces all outputs to their reset values immediately (asynchronous), even while the bus is acknowledging.
- Request to bus: `fetchRequest` accepted at edge 0; `busRequest`=1 from cycle 1.
- Ack in cycle k: write enable in cycle k; `fetchDone` in cycle k+1; `busy`=0 in cycle k+2, when a new request can be accepted.
- Zero-wait bus (ack in cycle 1): `fetchDone` in cycle 2.
- Misaligned PC: `fetchFault` in cycle 1.
- `fetchDone`/`fetchFault` and `faultCode` are registered. `instructionRegisterWriteEnable` is combinational from state, `busAck`, `busError` and `abort`.

## Configuration
- FETCH_TIMEOUT_EN defined: counter and timeout path are present, with behaviour as above.
- FETCH_TIMEOUT_EN undefined:
  - No counter is built; REQUEST waits indefinitely for `busAck` or `abort`.
  - `faultCode`=11 is never produced; TIMEOUT_CYCLES and COUNTER_WIDTH are ignored.

## Test plan
- Normal fetch: `pc`=0x0000_1000, `busAck` in the 3rd REQUEST cycle with data 0xDEADBEEF. Required response:
  - `busAddress`=0x0000_1000;
  - exactly one write-enable cycle, coincident with ack;
  - instruction register = 0xDEADBEEF;
  - `fetchDone` one cycle later, `faultCode`=00.
- Misaligned: `pc`=0x0000_1002. Required response: `busRequest` never asserted; `fetchFault` in cycle 1; `faultCode`=01.
- Bus error: `busAck`=`busError`=1 in cycle 1. Required response: no write enable, instruction register unchanged, `fetchFault` next cycle, `faultCode`=10.
- Abort: `abort`=1 coincident with `busAck` in cycle 2. Required response: no write enable, no done, no fault; back in IDLE and accepting a new request next cycle.
- Timeout (FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4), no ack. Required response: `fetchFault` after 4 REQUEST cycles, `faultCode`=11. Without the macro, no fault after 1000 cycles.
- Reset mid-fetch: `resetN` low during REQUEST. Required response: `busRequest`=0 and `busy`=0 immediately; after release, the next fetch completes normally.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// Purpose : sequences one word read on the bus per fetch request and loads the current instruction register.
// Latency : request accepted at edge 0, busRequest from cycle 1; ack in cycle k -> write enable in k, fetchDone in k+1.
// Backpr. : busRequest is held until busAck, abort or (with FETCH_TIMEOUT_EN) timeout; fetchRequest is ignored while busy.
//
// Ports:
//   clock, resetN                   - clock, asynchronous active-low reset
//   fetchRequest, pc                - start a fetch at pc (sampled in IDLE only)
//   abort                           - cancel an in-flight bus request
//   busRequest, busAddress          - bus read request and latched address
//   busAck, busError                - bus completion and error qualifier
//   instructionRegisterWriteEnable  - combinational load enable, coincident with a good ack
//   fetchDone, fetchFault           - registered one-cycle completion pulses
//   faultCode                       - 00 none, 01 misaligned, 10 bus error, 11 timeout
//   busy                            - state is not IDLE
//
// Build option: define FETCH_TIMEOUT_EN to build the wait counter and timeout fault.
module instruction_fetch_controller #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int COUNTER_WIDTH  = 8
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        fetchRequest,
    input  logic [31:0] pc,
    input  logic        abort,
    output logic        busRequest,
    output logic [31:0] busAddress,
    input  logic        busAck,
    input  logic        busError,
    output logic        instructionRegisterWriteEnable,
    output logic        fetchDone,
    output logic        fetchFault,
    output logic [1:0]  faultCode,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DONE    = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_BUSERR   = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

    state_t      state, state_nxt;
    logic [31:0] addr_nxt;
    logic [1:0]  code_nxt;
    logic        timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [COUNTER_WIDTH-1:0] wait_cnt, wait_cnt_nxt;

    // Counter holds the number of REQUEST cycles already spent without ack.
    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
`else
    // Without the timeout build the sizing parameters have no consumer.
    if (TIMEOUT_CYCLES < 0 && COUNTER_WIDTH < 0) begin : g_params_unused
    end
    assign timeout_hit = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            busAddress <= 32'h0;
            faultCode  <= CODE_NONE;
            fetchDone  <= 1'b0;
            fetchFault <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            state      <= state_nxt;
            busAddress <= addr_nxt;
            faultCode  <= code_nxt;
            fetchDone  <= (state_nxt == DONE);
            fetchFault <= (state_nxt == FAULT);
`ifdef FETCH_TIMEOUT_EN
            wait_cnt   <= wait_cnt_nxt;
`endif
        end
    end

    // Next-state logic. Inside REQUEST the priority is abort > ack > timeout.
    always_comb begin
        state_nxt = state;
        addr_nxt  = busAddress;
        code_nxt  = faultCode;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_nxt = wait_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (fetchRequest) begin
                    if (pc[1:0] == 2'b00) begin
                        addr_nxt  = pc;
                        code_nxt  = CODE_NONE;
                        state_nxt = REQUEST;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt_nxt = '0;
`endif
                    end else begin
                        // Misaligned: fault without touching the bus or the address latch.
                        code_nxt  = CODE_MISALIGN;
                        state_nxt = FAULT;
                    end
                end
            end
            REQUEST: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (busAck) begin
                    if (busError) begin
                        code_nxt  = CODE_BUSERR;
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    // Saturate rather than wrap.
                    wait_cnt_nxt = (wait_cnt == {COUNTER_WIDTH{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;
`endif
                    if (timeout_hit) begin
                        code_nxt  = CODE_TIMEOUT;
                        state_nxt = FAULT;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            FAULT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs. The write enable must land in the ack cycle itself so
    // the instruction register captures the bus data on that same edge.
    always_comb begin
        busRequest = (state == REQUEST);
        busy       = (state != IDLE);
        instructionRegisterWriteEnable = (state == REQUEST) && busAck && !busError && !abort;
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Purpose : directed bench for instruction_fetch_controller with a transaction-level reference model.
// Latency : inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Backpr. : the bench drives busAck/abort directly to exercise waits, errors, aborts and timeouts.
module tb_instruction_fetch_controller;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        fetchRequest = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        abort = 1'b0;
    logic        busAck = 1'b0;
    logic        busError = 1'b0;
    logic [31:0] busData = 32'h0;

    logic        busRequest;
    logic [31:0] busAddress;
    logic        we;
    logic        fetchDone;
    logic        fetchFault;
    logic [1:0]  faultCode;
    logic        busy;

    always #5 clock = ~clock;

    instruction_fetch_controller #(
        .TIMEOUT_CYCLES (T),
        .COUNTER_WIDTH  (8)
    ) dut (
        .clock                          (clock),
        .resetN                         (resetN),
        .fetchRequest                   (fetchRequest),
        .pc                             (pc),
        .abort                          (abort),
        .busRequest                     (busRequest),
        .busAddress                     (busAddress),
        .busAck                         (busAck),
        .busError                       (busError),
        .instructionRegisterWriteEnable (we),
        .fetchDone                      (fetchDone),
        .fetchFault                     (fetchFault),
        .faultCode                      (faultCode),
        .busy                           (busy)
    );

    // Current instruction register, loaded by the DUT's write enable.
    logic [31:0] ir = 32'h0;
    always @(posedge clock) if (we) ir <= busData;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int fault_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: a fetch is either outstanding on the bus, or its result
    // pulse is pending, or nothing is happening.
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    bit        m_active = 1'b0;
    bit [31:0] m_addr = 32'h0;
    int        m_waited = 0;
    int        m_pulse = 0;      // 0 none, 1 done, 2 fault
    bit [1:0]  m_code = 2'b00;
    bit [31:0] m_ir = 32'h0;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            m_active = 1'b0; m_addr = 32'h0; m_waited = 0; m_pulse = 0; m_code = 2'b00;
        end else if (m_pulse != 0) begin
            m_pulse = 0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 1'b0;
            end else if (busAck) begin
                m_active = 1'b0;
                if (busError) begin m_code = 2'b10; m_pulse = 2; end
                else begin m_ir = busData; m_pulse = 1; end
            end else begin
                m_waited++;
                if (TO_EN && m_waited == T) begin
                    m_active = 1'b0; m_code = 2'b11; m_pulse = 2;
                end
            end
        end else if (fetchRequest) begin
            if (pc[1:0] == 2'b00) begin
                m_active = 1'b1; m_addr = pc; m_code = 2'b00; m_waited = 0;
            end else begin
                m_code = 2'b01; m_pulse = 2;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        chk("busRequest", {31'b0, busRequest}, {31'b0, m_active});
        chk("busy",       {31'b0, busy},       {31'b0, (m_active || m_pulse != 0)});
        chk("we",         {31'b0, we},         {31'b0, (m_active && busAck && !busError && !abort)});
        chk("fetchDone",  {31'b0, fetchDone},  {31'b0, (m_pulse == 1)});
        chk("fetchFault", {31'b0, fetchFault}, {31'b0, (m_pulse == 2)});
        chk("faultCode",  {30'b0, faultCode},  {30'b0, m_code});
        chk("busAddress", busAddress, m_addr);
        chk("ir",         ir, m_ir);
        if (we) we_cnt++;
        if (fetchFault) fault_cnt++;
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clock);
        chk("rst_busAddress", busAddress, 32'h0);
        chk("rst_faultCode",  {30'b0, faultCode}, 32'h0);
        chk("rst_busy",       {31'b0, busy}, 32'h0);
        chk("rst_busRequest", {31'b0, busRequest}, 32'h0);
        chk("rst_done_fault", {30'b0, fetchDone, fetchFault}, 32'h0);
        tick();
        resetN = 1'b1;
        tick();

        // Normal fetch, ack in the third REQUEST cycle.
        we_cnt = 0;
        fetchRequest = 1'b1; pc = 32'h0000_1000;
        tick();                                   // cycle 1
        fetchRequest = 1'b0; pc = 32'h0;
        @(negedge clock);
        chk("norm_busRequest_c1", {31'b0, busRequest}, 32'h1);
        tick();                                   // cycle 2
        tick();                                   // cycle 3
        busAck = 1'b1; busData = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("norm_we_at_ack", {31'b0, we}, 32'h1);
        tick();                                   // cycle 4
        busAck = 1'b0; busData = 32'h0;
        @(negedge clock);
        chk("norm_done",       {31'b0, fetchDone}, 32'h1);
        chk("norm_ir",         ir, 32'hDEAD_BEEF);
        chk("norm_busAddress", busAddress, 32'h0000_1000);
        chk("norm_faultCode",  {30'b0, faultCode}, 32'h0);
        tick();                                   // cycle 5
        @(negedge clock);
        chk("norm_idle", {31'b0, busy}, 32'h0);
        chk("norm_we_count", we_cnt, 32'd1);

        // Misaligned PC.
        fetchRequest = 1'b1; pc = 32'h0000_1002;
        tick();
        fetchRequest = 1'b0;
        @(negedge clock);
        chk("mis_fault",      {31'b0, fetchFault}, 32'h1);
        chk("mis_busRequest", {31'b0, busRequest}, 32'h0);
        chk("mis_code",       {30'b0, faultCode}, 32'h1);
        tick();

        // Bus error in cycle 1.
        we_cnt = 0;
        fetchRequest = 1'b1; pc = 32'h0000_2000;
        tick();
        fetchRequest = 1'b0;
        busAck = 1'b1; busError = 1'b1; busData = 32'h1234_5678;
        @(negedge clock);
        chk("err_we", {31'b0, we}, 32'h0);
        tick();
        busAck = 1'b0; busError = 1'b0; busData = 32'h0;
        @(negedge clock);
        chk("err_fault", {31'b0, fetchFault}, 32'h1);
        chk("err_code",  {30'b0, faultCode}, 32'h2);
        chk("err_ir",    ir, 32'hDEAD_BEEF);
        tick();
        chk("err_we_count", we_cnt, 32'd0);

        // Abort coincident with ack in cycle 2, then a zero-wait fetch.
        we_cnt = 0;
        fetchRequest = 1'b1; pc = 32'h0000_3000;
        tick();                                   // cycle 1
        fetchRequest = 1'b0;
        tick();                                   // cycle 2
        abort = 1'b1; busAck = 1'b1; busData = 32'h5555_AAAA;
        @(negedge clock);
        chk("abt_we", {31'b0, we}, 32'h0);
        tick();                                   // cycle 3: idle again
        abort = 1'b0; busAck = 1'b0; busData = 32'h0;
        fetchRequest = 1'b1; pc = 32'h0000_3004;
        @(negedge clock);
        chk("abt_idle",        {31'b0, busy}, 32'h0);
        chk("abt_no_pulse",    {30'b0, fetchDone, fetchFault}, 32'h0);
        tick();                                   // new fetch cycle 1, zero wait
        fetchRequest = 1'b0;
        busAck = 1'b1; busData = 32'hCAFE_F00D;
        @(negedge clock);
        chk("zw_busAddress", busAddress, 32'h0000_3004);
        chk("zw_we",         {31'b0, we}, 32'h1);
        tick();                                   // new fetch cycle 2
        busAck = 1'b0; busData = 32'h0;
        @(negedge clock);
        chk("zw_done", {31'b0, fetchDone}, 32'h1);
        chk("zw_ir",   ir, 32'hCAFE_F00D);
        tick();
        chk("abt_we_count", we_cnt, 32'd1);

        // Timeout behaviour.
        fault_cnt = 0;
        fetchRequest = 1'b1; pc = 32'h0000_4000;
        tick();                                   // cycle 1
        fetchRequest = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (3) tick();                        // cycle 4: last REQUEST cycle
        @(negedge clock);
        chk("to_still_req", {31'b0, busRequest}, 32'h1);
        chk("to_no_fault",  {31'b0, fetchFault}, 32'h0);
        tick();                                   // cycle 5
        @(negedge clock);
        chk("to_fault", {31'b0, fetchFault}, 32'h1);
        chk("to_code",  {30'b0, faultCode}, 32'h3);
        tick();
`else
        repeat (1000) tick();
        @(negedge clock);
        chk("nto_still_req",  {31'b0, busRequest}, 32'h1);
        chk("nto_fault_count", fault_cnt, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clock);
        chk("nto_abort_idle", {31'b0, busy}, 32'h0);
`endif

        // Reset mid-fetch while the bus acknowledges.
        fetchRequest = 1'b1; pc = 32'h0000_5000;
        tick();
        fetchRequest = 1'b0;
        tick();
        busAck = 1'b1; busData = 32'h0BAD_0BAD;
        #2;
        resetN = 1'b0;
        #1;
        chk("rmid_busRequest", {31'b0, busRequest}, 32'h0);
        chk("rmid_busy",       {31'b0, busy}, 32'h0);
        chk("rmid_we",         {31'b0, we}, 32'h0);
        chk("rmid_busAddress", busAddress, 32'h0);
        tick();
        resetN = 1'b1; busAck = 1'b0; busData = 32'h0;
        tick();
        fetchRequest = 1'b1; pc = 32'h0000_6000;
        tick();
        fetchRequest = 1'b0;
        busAck = 1'b1; busData = 32'h600D_600D;
        tick();
        busAck = 1'b0; busData = 32'h0;
        @(negedge clock);
        chk("rpost_done", {31'b0, fetchDone}, 32'h1);
        chk("rpost_ir",   ir, 32'h600D_600D);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
